pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage core (ID/EX, EX/MEM, MEM/WB instances).

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_sat_counter.sv | 21 ++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and widths for the inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam int CTRL_W_DEF = 6;
  localparam int DATA_W_DEF = 133;

  // Bit positions inside the control vector
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_ZERO     = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter for the stage performance counters (PIPE_STAGE_PERF_EN builds only).
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid, flush and bubble squash.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  stage_state_t      state_p1;
  logic              ready_p1;
  logic [CTRL_W-1:0] main_ctrl_p1;
  logic [DATA_W-1:0] main_data_p1;
  logic [CTRL_W-1:0] skid_ctrl_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic              accept;
  logic              drain;

  assign in_ready  = ready_p1;
  assign out_valid = (state_p1 != ST_EMPTY);
  assign accept    = in_valid & ready_p1;
  assign drain     = out_valid & out_ready;
  assign out_ctrl  = main_ctrl_p1 & {CTRL_W{out_valid}};
  assign out_data  = main_data_p1;

  // Stage boundary: main holds the entry shown downstream, skid catches one entry during a stall.
  // ready_p1 is loaded with (next state != FULL) so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= ST_EMPTY;
      ready_p1     <= 1'b1;
      main_ctrl_p1 <= '0;
      main_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
    end else if (flush) begin
      state_p1 <= ST_EMPTY;
      ready_p1 <= 1'b1;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_p1 <= in_ctrl;
            main_data_p1 <= in_data;
            state_p1     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_p1 <= in_ctrl;
            main_data_p1 <= in_data;
          end else if (accept) begin
            skid_ctrl_p1 <= in_ctrl;
            skid_data_p1 <= in_data;
            state_p1     <= ST_FULL;
            ready_p1     <= 1'b0;
          end else if (drain) begin
            state_p1 <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_ctrl_p1 <= skid_ctrl_p1;
            main_data_p1 <= skid_data_p1;
            state_p1     <= ST_ONE;
            ready_p1     <= 1'b1;
          end
        end
        default: begin
          state_p1 <= ST_EMPTY;
          ready_p1 <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );
`else
  logic perf_unused;
  assign perf_unused = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, perf-counter sequences, randomized run vs queue model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 6;
  localparam int DW = 133;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt, bubble_cnt;
  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4, bubble_cnt4;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q[$];
  longint unsigned m_stall = 0, m_bubble = 0, m_stall4 = 0, m_bubble4 = 0;

  typedef struct {
    logic          rs, fl, iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          ev, er;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v, input longint unsigned mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Drive one cycle, advance the queue model at the edge, then compare the DUT with the model.
  task automatic step(input logic rs, input logic fl, input logic iv, input logic [CW-1:0] ic,
                      input logic [DW-1:0] id, input logic ordy);
    bit   acc, drn, v;
    ent_t e;
    reset = rs; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
    @(posedge clk);
    v   = (q.size() > 0);
    acc = iv && (q.size() < 2);
    drn = v && ordy;
    if (rs) begin
      m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
    end else begin
      if (v && !ordy) begin
        m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
        m_stall4 = sat_inc(m_stall4, 64'd15);
      end
      if (!v) begin
        m_bubble  = sat_inc(m_bubble, 64'hFFFF_FFFF);
        m_bubble4 = sat_inc(m_bubble4, 64'd15);
      end
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.c = ic; e.d = id;
        q.push_back(e);
      end
    end
    #1;
    chk("model_out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("model_in_ready", DW'(in_ready), DW'(q.size() < 2));
    chk("model_out_ctrl", DW'(out_ctrl), (q.size() > 0) ? DW'(q[0].c) : '0);
    if (q.size() > 0) chk("model_out_data", out_data, q[0].d);
`ifdef PIPE_STAGE_PERF_EN
    chk("model_stall_cnt", DW'(stall_cnt), DW'(m_stall));
    chk("model_bubble_cnt", DW'(bubble_cnt), DW'(m_bubble));
    chk("model_stall_cnt4", DW'(stall_cnt4), DW'(m_stall4));
    chk("model_bubble_cnt4", DW'(bubble_cnt4), DW'(m_bubble4));
`endif
  endtask

  task automatic add(input logic rs, input logic fl, input logic iv, input logic [CW-1:0] ic,
                     input logic [DW-1:0] id, input logic ordy, input logic ev, input logic er,
                     input logic [CW-1:0] ec, input logic [DW-1:0] ed);
    vec_t t;
    t.rs = rs; t.fl = fl; t.iv = iv; t.ic = ic; t.id = id; t.ordy = ordy;
    t.ev = ev; t.er = er; t.ec = ec; t.ed = ed;
    tbl.push_back(t);
  endtask

  initial begin
    logic [DW-1:0] rd;
    // Reset held two cycles with a valid input pending
    add(1, 0, 1, 6'h3F, 'hAA, 1, 0, 1, 6'h00, 0);
    add(1, 0, 1, 6'h3F, 'hAB, 1, 0, 1, 6'h00, 0);
    // Streaming, one-cycle latency, no gaps
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, CW'(i + 1), DW'(i), 1, 1, 1, CW'(i + 1), DW'(i));
    // Bubble with all control bits set on the idle input
    add(0, 0, 0, 6'h3F, 'hFF, 1, 0, 1, 6'h00, 0);
    // Stall: A held, B to skid, C refused, then A, B, C drain in order
    add(0, 0, 1, 6'h01, 'hA, 0, 1, 1, 6'h01, 'hA);
    add(0, 0, 1, 6'h02, 'hB, 0, 1, 0, 6'h01, 'hA);
    add(0, 0, 1, 6'h04, 'hC, 0, 1, 0, 6'h01, 'hA);
    add(0, 0, 1, 6'h04, 'hC, 1, 1, 1, 6'h02, 'hB);
    add(0, 0, 1, 6'h04, 'hC, 1, 1, 1, 6'h04, 'hC);
    add(0, 0, 0, 6'h3F, 0, 1, 0, 1, 6'h00, 0);
    // Flush while FULL with a valid input: everything lost
    add(0, 0, 1, 6'h08, 'hD, 0, 1, 1, 6'h08, 'hD);
    add(0, 0, 1, 6'h10, 'hE, 0, 1, 0, 6'h08, 'hD);
    add(0, 1, 1, 6'h3F, 'hF, 0, 0, 1, 6'h00, 0);
    add(0, 0, 0, 6'h3F, 0, 1, 0, 1, 6'h00, 0);
    // Reset (with flush) mid-stall discards main and skid
    add(0, 0, 1, 6'h20, 'h11, 0, 1, 1, 6'h20, 'h11);
    add(0, 0, 1, 6'h21, 'h12, 0, 1, 0, 6'h20, 'h11);
    add(1, 1, 1, 6'h3F, 'h13, 1, 0, 1, 6'h00, 0);
    add(0, 0, 0, 6'h00, 0, 1, 0, 1, 6'h00, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].fl, tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].ev));
      chk($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].er));
      chk($sformatf("vec%0d_out_ctrl", i), DW'(out_ctrl), DW'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].ed);
    end

`ifdef PIPE_STAGE_PERF_EN
    step(1, 0, 0, '0, '0, 0);
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 1, 6'h01, 'h55, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 1);
    chk("perf_stall_5", DW'(stall_cnt), DW'(5));
    chk("perf_bubble_ge3", DW'(bubble_cnt >= 3), DW'(1));
    step(0, 0, 1, 6'h01, 'h56, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0, 0);
    chk("perf_stall4_sat", DW'(stall_cnt4), DW'(15));
    step(0, 1, 0, '0, '0, 1);
    chk("perf_flush_keeps_stall", DW'(stall_cnt), DW'(25));
`endif

    step(1, 0, 0, '0, '0, 1);
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), 5'($urandom())};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 3) != 0), CW'($urandom()), rd, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
